// File: rtl/tom_regwr_seq.sv
// tom_regwr_seq: CPU bus-cycle sequencer feeding the TOM settable-latch registers.
// Define TOM_REGWR_BYTE_EN for per-byte latch load enables steered by bus_be.
module tom_regwr_seq #(
  parameter int         NREG        = 8,
  parameter logic [7:0] BASE_ADDR   = 8'h00,
  parameter int         WAIT_STATES = 0
) (
  input  logic               sys_clk,
  input  logic               resetl,
  input  logic               bus_strobe,
  input  logic               bus_rw,
  input  logic [7:0]         bus_addr,
  input  logic [15:0]        bus_din,
  input  logic [1:0]         bus_be,
  input  logic [16*NREG-1:0] reg_q,
  output logic [15:0]        reg_d,
`ifdef TOM_REGWR_BYTE_EN
  output logic [2*NREG-1:0]  reg_en,
`else
  output logic [NREG-1:0]    reg_en,
`endif
  output logic               setl,
  output logic               bus_ack,
  output logic [15:0]        bus_dout,
  output logic               bus_err
);

`ifdef TOM_REGWR_BYTE_EN
  localparam int EW = 2 * NREG;
`else
  localparam int EW = NREG;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_STROBE,
    S_WAIT,
    S_ACK,
    S_RELEASE
  } state_t;

  state_t        state_q, state_d;
  logic          rw_q, rw_d;
  logic [7:0]    addr_q, addr_d;
  logic [15:0]   data_q, data_d;
  logic [1:0]    be_q, be_d;
  logic          hit_q, hit_d;
  logic [4:0]    idx_q, idx_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [EW-1:0] en_q, en_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic [15:0]   dout_q, dout_d;
  logic          setl_q;

  logic [8:0]    diff;
  logic [15:0]   rdata;
  logic [EW-1:0] wr_mask;

  // 9-bit subtract: addresses below the base land above 255, never a hit
  assign diff = {1'b0, addr_q} - {1'b0, BASE_ADDR};

  always_comb begin
    rdata   = '0;
    wr_mask = '0;
    for (int i = 0; i < NREG; i++) begin
      if (idx_q == 5'(i)) begin
        rdata = reg_q[16*i +: 16];
`ifdef TOM_REGWR_BYTE_EN
        wr_mask[2*i]   = be_q[0];
        wr_mask[2*i+1] = be_q[1];
`else
        wr_mask[i]     = 1'b1;
`endif
      end
    end
  end

`ifndef TOM_REGWR_BYTE_EN
  logic unused_be;
  assign unused_be = ^be_q;
`endif

  always_comb begin
    state_d = state_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    data_d  = data_q;
    be_d    = be_q;
    hit_d   = hit_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    en_d    = '0;
    ack_d   = ack_q;
    err_d   = err_q;
    dout_d  = dout_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus_strobe) begin
          rw_d    = bus_rw;
          addr_d  = bus_addr;
          data_d  = bus_din;
          be_d    = bus_be;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        hit_d   = diff < 9'(NREG);
        idx_d   = diff[4:0];
        cnt_d   = 4'(WAIT_STATES);
        state_d = S_STROBE;
      end
      S_STROBE: begin
        if (hit_q && !rw_q) begin
          en_d = wr_mask;
        end
        if (rw_q) begin
          dout_d = hit_q ? rdata : 16'hFFFF;
        end
        state_d = (WAIT_STATES > 0) ? S_WAIT : S_ACK;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        ack_d = 1'b1;
        err_d = !hit_q;
        // first ACK cycle always acks, even if strobe already dropped
        if (ack_q && !bus_strobe) begin
          ack_d   = 1'b0;
          err_d   = 1'b0;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    setl_q <= resetl;
    if (!resetl) begin
      state_q <= S_IDLE;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      be_q    <= '0;
      hit_q   <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      en_q    <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      be_q    <= be_d;
      hit_q   <= hit_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
    end
  end

  assign reg_d    = data_q;
  assign reg_en   = en_q;
  assign setl     = setl_q;
  assign bus_ack  = ack_q;
  assign bus_dout = dout_q;
  assign bus_err  = err_q;

endmodule
